// File: rtl/resampler_axis_tx.sv
// Backpressured AXI-Stream master for the resampler output: small FIFO, tlast framing,
// and drop-with-count when storage is full so the upstream DSP chain never stalls.
module resampler_axis_tx #(
  parameter int CH_NUM      = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WIDTH = 16,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic                                clear_i,
  input  logic [FRAME_WIDTH-1:0]              frame_len_i,
  input  logic                                tvalid_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0]        tdata_i,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [CH_NUM*DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                                m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH+2)-1:0]     level_o,
  output logic                                overflow_o,
  output logic [DROP_WIDTH-1:0]               drop_cnt_o
);

  localparam int DW = CH_NUM * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 2);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Each storage entry carries the sample plus the tlast bit decided at write time.
  logic [DW:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_count;
  out_state_t             r_state;
  out_state_t             w_stateNext;
  logic [DW-1:0]          r_tdata;
  logic                   r_tlast;
  logic [FRAME_WIDTH-1:0] r_frameCnt;
  logic [FRAME_WIDTH-1:0] r_frameLen;
  logic                   r_overflow;
  logic [DROP_WIDTH-1:0]  r_dropCnt;

  logic                   w_full;
  logic                   w_notEmpty;
  logic                   w_wr;
  logic                   w_drop;
  logic                   w_load;
  logic [FRAME_WIDTH-1:0] w_curLen;
  logic [FRAME_WIDTH-1:0] w_lenMinus1;
  logic                   w_lastHit;

  // Full is judged on registered occupancy only, so a same-cycle read never frees a slot.
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_notEmpty = (r_count != '0);
  assign w_wr       = tvalid_i && en_i && !w_full;
  assign w_drop     = tvalid_i && en_i && w_full;

  // A new frame length is only sampled while the counter sits at the start of a frame.
  assign w_curLen    = (r_frameCnt == '0) ? frame_len_i : r_frameLen;
  assign w_lenMinus1 = w_curLen - FRAME_WIDTH'(1);
  assign w_lastHit   = (w_curLen != '0) && (r_frameCnt == w_lenMinus1);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wrPtr] <= {w_lastHit, tdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_load) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_wr, w_load})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frameCnt <= '0;
      r_frameLen <= '0;
    end else if (w_wr) begin
      if (r_frameCnt == '0) begin
        r_frameLen <= frame_len_i;
      end
      if (w_lastHit || (w_curLen == '0)) begin
        r_frameCnt <= '0;
      end else begin
        r_frameCnt <= r_frameCnt + FRAME_WIDTH'(1);
      end
    end
  end

  // Clear has priority over a coincident drop; later drops count from zero again.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCnt != '1) begin
        r_dropCnt <= r_dropCnt + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_notEmpty) begin
          w_load      = 1'b1;
          w_stateNext = ST_FULL;
        end
      end
      ST_FULL: begin
        if (m_axis_tready) begin
          if (w_notEmpty) begin
            w_load = 1'b1;
          end else begin
            w_stateNext = ST_EMPTY;
          end
        end
      end
      default: begin
        w_stateNext = ST_EMPTY;
      end
    endcase
  end

  // The output register only changes on a load, which keeps data stable while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else if (w_load) begin
      {r_tlast, r_tdata} <= r_mem[r_rdPtr];
    end
  end

  assign m_axis_tvalid = (r_state == ST_FULL);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign level_o       = LW'(r_count) + LW'(r_state == ST_FULL);
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_dropCnt;

endmodule

// File: tb/tb_resampler_axis_tx.sv
// Directed bench for resampler_axis_tx: framing, overflow/drop, stalls, reset, enable and clear.
module tb_resampler_axis_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic        clear_i = 1'b0;
  logic [15:0] frame_len_i = 16'd0;
  logic        tvalid_i = 1'b0;
  logic [31:0] tdata_i = 32'd0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  resampler_axis_tx dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .frame_len_i   (frame_len_i),
    .tvalid_i      (tvalid_i),
    .tdata_i       (tdata_i),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    tvalid_i = v;
    tdata_i  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] readyPat;
    int nextBeat;

    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_overflow", overflow_o, 0);
    checkOutput("rst_drop", drop_cnt_o, 0);

    // Eight samples, frame length 4, no backpressure: two-cycle latency
    frame_len_i   = 16'd4;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 8, 32'(i + 1));
      tick();
      if (i == 0) begin
        checkOutput("t1_latency", m_axis_tvalid, 0);
      end else if (i <= 8) begin
        checkOutput("t1_valid", m_axis_tvalid, 1);
        checkOutput("t1_data", m_axis_tdata, 64'(i));
        checkOutput("t1_last", m_axis_tlast, (i == 4 || i == 8) ? 1 : 0);
      end
    end
    checkOutput("t1_idle_valid", m_axis_tvalid, 0);
    checkOutput("t1_idle_level", level_o, 0);

    // Twenty samples into a stalled sink: 17 held, 3 dropped
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i + 1));
      tick();
    end
    applyStimulus(1'b0, 32'd0);
    checkOutput("ovf_level", level_o, 17);
    checkOutput("ovf_flag", overflow_o, 1);
    checkOutput("ovf_drop", drop_cnt_o, 3);
    checkOutput("ovf_head", m_axis_tdata, 1);
    m_axis_tready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      checkOutput("ovf_drain_valid", m_axis_tvalid, 1);
      checkOutput("ovf_drain_data", m_axis_tdata, 64'(b + 1));
      checkOutput("ovf_drain_last", m_axis_tlast, (((b + 1) % 4) == 0) ? 1 : 0);
      tick();
    end
    checkOutput("ovf_after_valid", m_axis_tvalid, 0);
    checkOutput("ovf_after_level", level_o, 0);

    // Mid-burst reset discards five buffered samples and restarts framing
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(16'h50 + i));
      tick();
    end
    applyStimulus(1'b0, 32'd0);
    checkOutput("prerst_level", level_o, 5);
    checkOutput("prerst_overflow", overflow_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("midrst_valid", m_axis_tvalid, 0);
    checkOutput("midrst_level", level_o, 0);
    checkOutput("midrst_overflow", overflow_o, 0);
    checkOutput("midrst_drop", drop_cnt_o, 0);
    frame_len_i   = 16'd1;
    m_axis_tready = 1'b1;
    applyStimulus(1'b1, 32'h0000_AAAA);
    tick();
    applyStimulus(1'b0, 32'd0);
    checkOutput("postrst_lat", m_axis_tvalid, 0);
    tick();
    checkOutput("postrst_valid", m_axis_tvalid, 1);
    checkOutput("postrst_data", m_axis_tdata, 32'h0000_AAAA);
    checkOutput("postrst_last", m_axis_tlast, 1);
    tick();
    checkOutput("postrst_done", m_axis_tvalid, 0);

    // Overflow then clear, including clear colliding with a drop; frame length 0
    frame_len_i   = 16'd0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 32'(16'h200 + i));
      tick();
    end
    checkOutput("clr_pre_flag", overflow_o, 1);
    checkOutput("clr_pre_drop", drop_cnt_o, 1);
    checkOutput("clr_pre_level", level_o, 17);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("clr_win_flag", overflow_o, 0);
    checkOutput("clr_win_drop", drop_cnt_o, 0);
    tick();
    checkOutput("clr_resume_flag", overflow_o, 1);
    checkOutput("clr_resume_drop", drop_cnt_o, 1);
    applyStimulus(1'b0, 32'd0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("clr_flag", overflow_o, 0);
    checkOutput("clr_drop", drop_cnt_o, 0);
    m_axis_tready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      checkOutput("nolast_valid", m_axis_tvalid, 1);
      checkOutput("nolast_data", m_axis_tdata, 64'(16'h200 + b));
      checkOutput("nolast_last", m_axis_tlast, 0);
      tick();
    end
    checkOutput("nolast_level", level_o, 0);

    // Frame length changes from 4 to 3 mid-frame
    frame_len_i = 16'd4;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) frame_len_i = 16'd3;
      applyStimulus(i < 10, 32'(i + 1));
      tick();
      if (i == 0) begin
        checkOutput("fl_latency", m_axis_tvalid, 0);
      end else if (i <= 10) begin
        checkOutput("fl_valid", m_axis_tvalid, 1);
        checkOutput("fl_data", m_axis_tdata, 64'(i));
        checkOutput("fl_last", m_axis_tlast, (i == 4 || i == 7 || i == 10) ? 1 : 0);
      end
    end
    checkOutput("fl_idle", m_axis_tvalid, 0);

    // Six-sample burst with tready stalls; data must hold and nothing is lost
    frame_len_i = 16'd4;
    readyPat    = 16'b1111_1111_1110_0111;
    nextBeat    = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(c < 6, 32'(16'h100 + c));
      m_axis_tready = readyPat[c];
      if (m_axis_tvalid) begin
        checkOutput("stall_data", m_axis_tdata, 64'(16'h100 + nextBeat));
        checkOutput("stall_last", m_axis_tlast, (nextBeat == 3) ? 1 : 0);
        if (m_axis_tready) nextBeat++;
      end
      tick();
    end
    checkOutput("stall_beats", 64'(nextBeat), 6);
    checkOutput("stall_idle", m_axis_tvalid, 0);

    // Enable low gates new samples while the two pending ones drain
    m_axis_tready = 1'b0;
    applyStimulus(1'b1, 32'h21);
    tick();
    applyStimulus(1'b1, 32'h22);
    tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(16'h31 + i));
      tick();
    end
    checkOutput("en_level", level_o, 2);
    checkOutput("en_drop", drop_cnt_o, 0);
    m_axis_tready = 1'b1;
    applyStimulus(1'b1, 32'h34);
    checkOutput("en_beat0", m_axis_tdata, 32'h21);
    tick();
    checkOutput("en_beat1_valid", m_axis_tvalid, 1);
    checkOutput("en_beat1", m_axis_tdata, 32'h22);
    tick();
    applyStimulus(1'b0, 32'd0);
    checkOutput("en_done_valid", m_axis_tvalid, 0);
    checkOutput("en_done_level", level_o, 0);
    checkOutput("en_done_drop", drop_cnt_o, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resampler_axis_tx.md
Name: resampler_axis_tx

Overview:
- Output-side companion to the resampler. The resampler emits unthrottled tvalid/tdata with no backpressure; this block turns that into a backpressured AXI-Stream master.
- Accepted samples are buffered in a small FIFO, framed with tlast every frame_len_i samples, and presented on m_axis with full AXI-Stream hold rules.
- Samples that arrive while the FIFO storage is full are dropped and counted, so the DSP chain never stalls.

Parameters:
- CH_NUM, 2, number of parallel channels per sample
- DATA_WIDTH, 16, bits per channel
- FIFO_DEPTH, 16, storage entries excluding the output register; power of two, minimum 2
- FRAME_WIDTH, 16, width of frame_len_i and of the internal frame counter
- DROP_WIDTH, 16, width of the saturating drop counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  input enable; when low, tvalid_i is ignored
- clear_i  in  1  clears overflow_o and drop_cnt_o
- frame_len_i  in  FRAME_WIDTH  samples per frame; 0 = no tlast
- tvalid_i  in  1  sample strobe from resampler
- tdata_i  in  CH_NUM x DATA_WIDTH  packed channels, channel 0 in LSBs
- m_axis_tvalid  out  1  AXI-Stream valid
- m_axis_tready  in  1  AXI-Stream ready
- m_axis_tdata  out  CH_NUM*DATA_WIDTH  sample, same packing as tdata_i
- m_axis_tlast  out  1  last sample of frame
- level_o  out  $clog2(FIFO_DEPTH+2)  occupancy: storage entries + output register valid
- overflow_o  out  1  sticky: at least one sample dropped
- drop_cnt_o  out  DROP_WIDTH  dropped samples, saturating at all-ones

Behaviour:
- Reset (rst_i=1 at a clk_i edge) gives, from the next cycle:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
  - level_o=0, overflow_o=0, drop_cnt_o=0
  - FIFO pointers and frame counter cleared
  - Reset mid-burst discards all buffered data.
- Write (accept): tvalid_i && en_i && !full.
  - full = storage count == FIFO_DEPTH, taken from registered state.
  - A read in the same cycle does not unblock the write; there is no pass-through while full.
- Drop: tvalid_i && en_i && full.
  - overflow_o sets the next cycle.
  - drop_cnt_o increments, saturating.
  - The frame counter does not advance.
- clear_i: clears overflow_o and drop_cnt_o next cycle. If a drop occurs in the same cycle, the clear wins for that cycle; counting resumes on later drops.
- Framing:
  - Frame counter counts accepted samples. The tlast bit is computed at write time and stored alongside the data.
  - frame_len_i is latched when the counter is 0 (start of frame); the latched value L applies to the whole frame.
  - Sample k (0-based) gets tlast = (k == L-1); the counter wraps to 0 after it.
  - L=0: tlast is never set and the counter stays 0, so frame_len_i is re-latched on every write.
- Output stage, two states:
  - EMPTY (m_axis_tvalid=0): loads the head entry when storage is non-empty.
  - FULL (m_axis_tvalid=1): on m_axis_tready, loads the next entry if available and stays FULL; otherwise goes to EMPTY.
  - While tvalid && !tready, tdata and tlast are held stable.
  - Samples are never duplicated or reordered.
- Latency: with FIFO and output register empty, a sample accepted in cycle N is presented (m_axis_tvalid=1) in cycle N+2. Stage 1 is the storage write; stage 2 is the output register load.
- Throughput: 1 sample/cycle sustained when m_axis_tready=1.
- level_o: updated each cycle. Simultaneous accept and output transfer leaves it unchanged. Maximum value is FIFO_DEPTH+1.
- en_i=0 gates input only; buffered data keeps draining.

Test Plan:
- frame_len_i=4, m_axis_tready=1, 8 consecutive samples 0x0001..0x0008 on ch0 → 8 beats in order, first beat 2 cycles after first tvalid_i, tlast on beats 4 and 8, level_o back to 0.
- FIFO_DEPTH=16, m_axis_tready=0, 20 consecutive samples → level_o=17 (16 storage + output register); samples 18–20 dropped; overflow_o=1; drop_cnt_o=3. Then tready=1 → exactly 17 beats, values 1..17 in order.
- m_axis_tready toggles 1,0,0,1 during a 6-sample burst → tdata and tlast constant while stalled, 6 distinct beats, no loss.
- frame_len_i changed from 4 to 3 after sample 2 → first frame ends on sample 4, next frames end on samples 7 and 10. frame_len_i=0 → no tlast over 10 samples.
- rst_i pulsed for 1 cycle with level_o=5 and overflow_o=1 → next cycle tvalid=0, level_o=0, overflow_o=0, drop_cnt_o=0. Post-reset sample 0xAAAA emerges with tlast per a fresh frame count.
- en_i=0 with 3 tvalid_i pulses while 2 entries are pending → only the 2 pending beats are output, and drop_cnt_o is unchanged. clear_i after an overflow → overflow_o=0 and drop_cnt_o=0 next cycle.
